// File: rtl/bcd_mmss_timer.sv
// -----------------------------------------------------------------------------
// bcd_mmss_timer
//
// mm:ss up/down timer producing the four BCD digits for a 4-digit seven-segment
// decoder. A prescaler divides the system clock down to a one-second tick.
// Each tick moves the displayed time by one second, either up (stopwatch) or
// down (countdown). Counting stops at 99:59 going up and at 00:00 going down.
//
// Parameters
//   TICK_DIV        clock cycles per one-second tick (>= 2)
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           pulse: begin (IDLE/DONE) or resume (PAUSED) counting
//   pause           pulse: freeze count while running
//   clear           pulse: return to 00:00 and IDLE from any state
//   load            pulse: load ld_* digits (IDLE/PAUSED/DONE only)
//   count_down      direction, latched on start from IDLE/DONE (1 = down)
//   ld_second_unit  load value 0-9
//   ld_second_tens  load value 0-5
//   ld_minute_unit  load value 0-9
//   ld_minute_tens  load value 0-9
//   second_unit     BCD seconds units
//   second_tens     BCD seconds tens (0-5)
//   minute_unit     BCD minutes units
//   minute_tens     BCD minutes tens
//   running         high while in RUN
//   done            one-cycle pulse when the terminal value is reached
//   load_err        one-cycle pulse when a load carries an invalid digit
// -----------------------------------------------------------------------------
module bcd_mmss_timer #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic       count_down,
  input  logic [3:0] ld_second_unit,
  input  logic [3:0] ld_second_tens,
  input  logic [3:0] ld_minute_unit,
  input  logic [3:0] ld_minute_tens,
  output logic [3:0] second_unit,
  output logic [3:0] second_tens,
  output logic [3:0] minute_unit,
  output logic [3:0] minute_tens,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  localparam int unsigned     PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  // Packed time layout: {minute_tens, minute_unit, second_tens, second_unit}
  localparam logic [15:0]     TIME_MAX   = 16'h9959;
  localparam logic [15:0]     TIME_ZERO  = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   digits;
  logic          dir_down;

  logic [15:0]   ld_value;
  logic          ld_ok;
  logic [15:0]   next_up;
  logic [15:0]   next_down;
  logic [15:0]   next_time;
  logic          next_terminal;
  logic          start_terminal;
  logic          advance;
  logic          tick;

  // One-second increment with carry chain; saturates at 99:59.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] s0, s1, m0, m1;
    {m1, m0, s1, s0} = v;
    if (v == TIME_MAX) begin
      return v;
    end
    if (s0 != 4'd9) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m0 != 4'd9) begin
          m0 = m0 + 4'd1;
        end else begin
          m0 = 4'd0;
          m1 = m1 + 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // One-second decrement with borrow chain; saturates at 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] s0, s1, m0, m1;
    {m1, m0, s1, s0} = v;
    if (v == TIME_ZERO) begin
      return v;
    end
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  always_comb begin
    ld_value = {ld_minute_tens, ld_minute_unit, ld_second_tens, ld_second_unit};
    ld_ok    = (ld_second_unit <= 4'd9) && (ld_second_tens <= 4'd5) &&
               (ld_minute_unit <= 4'd9) && (ld_minute_tens <= 4'd9);

    next_up       = bcd_inc(digits);
    next_down     = bcd_dec(digits);
    next_time     = dir_down ? next_down : next_up;
    next_terminal = dir_down ? (next_time == TIME_ZERO) : (next_time == TIME_MAX);

    // Terminal check on start uses the direction being latched, not dir_down.
    start_terminal = count_down ? (digits == TIME_ZERO) : (digits == TIME_MAX);

    // In RUN only clear and pause change anything; start/load arriving while
    // running still consume the cycle's priority slot but counting carries on.
    advance = (state == S_RUN) && !clear && !(pause && !load && !start);
    tick    = advance && (presc == PRESC_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      presc    <= '0;
      digits   <= '0;
      dir_down <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;

      if (clear) begin
        digits  <= '0;
        presc   <= '0;
        state   <= S_IDLE;
        running <= 1'b0;
      end else if (load) begin
        if (state != S_RUN) begin
          if (ld_ok) begin
            digits  <= ld_value;
            presc   <= '0;
            state   <= S_IDLE;
            running <= 1'b0;
          end else begin
            load_err <= 1'b1;
          end
        end
      end else if (start) begin
        if (state == S_PAUSED) begin
          // Resume keeps the partial prescaler count and latched direction.
          state   <= S_RUN;
          running <= 1'b1;
        end else if (state != S_RUN) begin
          dir_down <= count_down;
          presc    <= '0;
          if (start_terminal) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
      end else if (pause) begin
        if (state == S_RUN) begin
          state   <= S_PAUSED;
          running <= 1'b0;
        end
      end

      if (advance) begin
        if (tick) begin
          presc  <= '0;
          digits <= next_time;
          if (next_terminal) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  assign second_unit = digits[3:0];
  assign second_tens = digits[7:4];
  assign minute_unit = digits[11:8];
  assign minute_tens = digits[15:12];

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd_mmss_timer
//
// Directed bench for bcd_mmss_timer with TICK_DIV = 4. Inputs change on the
// falling edge; outputs are sampled on the falling edge, half a cycle after the
// rising edge that produced them. Observed state is {digits, running, done,
// load_err}, with digits packed as mm:ss hex (e.g. 16'h0059 = 00:59).
// -----------------------------------------------------------------------------
module tb_bcd_mmss_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic       count_down = 1'b0;
  logic [3:0] ld_second_unit = '0;
  logic [3:0] ld_second_tens = '0;
  logic [3:0] ld_minute_unit = '0;
  logic [3:0] ld_minute_tens = '0;
  logic [3:0] second_unit;
  logic [3:0] second_tens;
  logic [3:0] minute_unit;
  logic [3:0] minute_tens;
  logic       running;
  logic       done;
  logic       load_err;

  logic [18:0] obs;
  logic [18:0] exp;
  int vectors = 0;
  int errors  = 0;

  assign obs = {minute_tens, minute_unit, second_tens, second_unit, running, done, load_err};

  bcd_mmss_timer #(.TICK_DIV(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .pause          (pause),
    .clear          (clear),
    .load           (load),
    .count_down     (count_down),
    .ld_second_unit (ld_second_unit),
    .ld_second_tens (ld_second_tens),
    .ld_minute_unit (ld_minute_unit),
    .ld_minute_tens (ld_minute_tens),
    .second_unit    (second_unit),
    .second_tens    (second_tens),
    .minute_unit    (minute_unit),
    .minute_tens    (minute_tens),
    .running        (running),
    .done           (done),
    .load_err       (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    {ld_minute_tens, ld_minute_unit, ld_second_tens, ld_second_unit} = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start(input logic dn);
    count_down = dn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    exp = {16'h0000, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL reset_init: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    do_load(16'h0007);
    do_start(1'b0);
    step(2);
    exp = {16'h0007, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL reset_prerun: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    #2 rst_n = 1'b0;
    #1;
    exp = {16'h0000, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL reset_async: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    exp = {16'h0000, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL reset_idle_hold: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
  endtask

  task automatic test_count_up();
    do_load(16'h0058);
    do_start(1'b0);
    step(3);
    exp = {16'h0058, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL up_pre_tick: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(1);
    exp = {16'h0059, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL up_0059: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(3);
    exp = {16'h0059, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL up_0059_hold: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(1);
    exp = {16'h0100, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL up_carry_0100: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    // load while running is ignored without an error pulse
    do_load(16'h0505);
    exp = {16'h0100, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL up_load_in_run: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
  endtask

  task automatic test_count_down();
    do_clear();
    do_load(16'h1000);
    do_start(1'b1);
    step(3);
    exp = {16'h1000, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL dn_pre_tick: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(1);
    exp = {16'h0959, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL dn_borrow_0959: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    do_clear();
    do_load(16'h0002);
    do_start(1'b1);
    step(4);
    exp = {16'h0001, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL dn_0001: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(3);
    exp = {16'h0001, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL dn_pre_terminal: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(1);
    exp = {16'h0000, 3'b010}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL dn_terminal_done: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    for (int i = 0; i < 22; i++) begin
      step(1);
      exp = {16'h0000, 3'b000}; vectors++;
      if (obs !== exp) begin errors++; $display("FAIL dn_hold_%0d: got %h_%b want %h_%b", i, obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    end
    // countdown start at 00:00 from IDLE finishes immediately
    do_clear();
    do_start(1'b1);
    exp = {16'h0000, 3'b010}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL dn_start_at_zero: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(1);
    exp = {16'h0000, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL dn_start_at_zero_after: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
  endtask

  task automatic test_pause_resume();
    do_clear();
    do_start(1'b0);
    step(2);
    do_pause();
    exp = {16'h0000, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL pause_enter: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(10);
    exp = {16'h0000, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL pause_frozen: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    // direction input on resume must not change the latched direction
    do_start(1'b1);
    exp = {16'h0000, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL resume_run: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(1);
    exp = {16'h0000, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL resume_pre_tick: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(1);
    exp = {16'h0001, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL resume_tick: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
  endtask

  task automatic test_load_reject();
    do_clear();
    do_load(16'h1234);
    exp = {16'h1234, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL load_ok: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    do_load(16'h0069);
    exp = {16'h1234, 3'b001}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL load_bad_tens: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(1);
    exp = {16'h1234, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL load_err_pulse_end: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    do_load(16'h123A);
    exp = {16'h1234, 3'b001}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL load_bad_unit: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    {ld_minute_tens, ld_minute_unit, ld_second_tens, ld_second_unit} = 16'h0069;
    count_down = 1'b0;
    clear = 1'b1; load = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; load = 1'b0; start = 1'b0;
    exp = {16'h0000, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL prio_clear_wins: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(6);
    exp = {16'h0000, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL prio_idle_hold: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
  endtask

  task automatic test_saturate();
    do_load(16'h9958);
    do_start(1'b0);
    step(3);
    exp = {16'h9958, 3'b100}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL sat_pre_tick: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    step(1);
    exp = {16'h9959, 3'b010}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL sat_done: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    for (int i = 0; i < 12; i++) begin
      step(1);
      exp = {16'h9959, 3'b000}; vectors++;
      if (obs !== exp) begin errors++; $display("FAIL sat_hold_%0d: got %h_%b want %h_%b", i, obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    end
    // count-up start at 99:59 finishes immediately
    do_start(1'b0);
    exp = {16'h9959, 3'b010}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL sat_restart_done: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
    // load accepted from DONE returns to IDLE
    do_load(16'h0030);
    exp = {16'h0030, 3'b000}; vectors++;
    if (obs !== exp) begin errors++; $display("FAIL load_from_done: got %h_%b want %h_%b", obs[18:3], obs[2:0], exp[18:3], exp[2:0]); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_pause_resume();
    test_load_reject();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
